// File: rtl/rct_w2m_bridge.sv
// rct_w2m_bridge: Wishbone classic slave to mem_if request/response master.
// Accepts one Wishbone cycle at a time, issues a tagged 87-bit mem_if
// request, waits for the 51-bit response carrying the same tid, then ends
// the Wishbone cycle with ack or err. A response timeout keeps the bus from
// hanging. A cycle dropped by the master mid-flight still completes on
// mem_if, but it ends silently.
module rct_w2m_bridge #(
    parameter int          BUS_WIDTH      = 32,
    parameter int          BUS_MASK       = 4,
    parameter logic [3:0]  SRCID          = 4'h0,
    parameter logic [3:0]  RID            = 4'h0,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic [BUS_WIDTH-1:0] wb_addr_i,
    input  logic                 wb_we_i,
    input  logic [BUS_WIDTH-1:0] wb_data_i,
    input  logic [BUS_MASK-1:0]  wb_sel_i,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic [BUS_WIDTH-1:0] wb_data_o,
    output logic                 mem_if_req_valid,
    input  logic                 mem_if_req_ready,
    output logic [86:0]          mem_if_req,
    input  logic                 mem_if_resp_valid,
    output logic                 mem_if_resp_ready,
    input  logic [50:0]          mem_if_resp
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_TERM = 2'd3;

    localparam logic [2:0] OP_READ  = 3'b000;
    localparam logic [2:0] OP_WRITE = 3'b001;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [7:0]  tid_cnt;
    logic [15:0] timeout_cnt;
    logic        aborted;

    // Request handshake and response decode.
    logic        req_fire;
    logic        resp_fire;
    logic [15:0] resp_tid;
    logic [2:0]  resp_op;
    logic [31:0] resp_data;
    logic        resp_match;
    logic        resp_ok;
    logic        timeout_hit;
    logic        abort_now;
    logic        req_is_write;
    logic [15:0] issued_tid;
    logic [15:0] new_tid;

    assign req_fire     = mem_if_req_valid & mem_if_req_ready;
    assign resp_fire    = mem_if_resp_valid & mem_if_resp_ready;
    assign resp_tid     = mem_if_resp[50:35];
    assign resp_op      = mem_if_resp[34:32];
    assign resp_data    = mem_if_resp[31:0];
    assign issued_tid   = mem_if_req[86:71];
    assign req_is_write = (mem_if_req[70:68] == OP_WRITE);
    assign new_tid      = {RID, SRCID, tid_cnt};
    assign resp_match   = resp_fire && (resp_tid == issued_tid);
    // Only the two success codes are ok; op[2] and every unknown code are errors.
    assign resp_ok      = (resp_op == OP_READ) || (resp_op == OP_WRITE);
    assign timeout_hit  = (timeout_cnt == TIMEOUT_LAST);
    // The master may drop cyc on the very edge the transaction resolves.
    assign abort_now    = aborted | ~wb_cyc_i;

    // Next-state selection for the single-outstanding-request controller.
    always_comb begin
        // NOTE: default assignment first so every path drives next_state and no latch is inferred.
        next_state = state;
        case (state)
            ST_IDLE: if (wb_cyc_i && wb_stb_i)          next_state = ST_REQ;
            ST_REQ:  if (req_fire)                      next_state = ST_WAIT;
            ST_WAIT: if (resp_match || timeout_hit)     next_state = ST_TERM;
            ST_TERM:                                    next_state = ST_IDLE;
            default:                                    next_state = ST_IDLE;
        endcase
    end

    // State, request payload, counters and Wishbone termination registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= ST_IDLE;
            tid_cnt           <= 8'h00;
            timeout_cnt       <= 16'h0000;
            aborted           <= 1'b0;
            mem_if_req_valid  <= 1'b0;
            mem_if_req        <= '0;
            mem_if_resp_ready <= 1'b0;
            wb_ack_o          <= 1'b0;
            wb_err_o          <= 1'b0;
            wb_data_o         <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; a later assignment in this block overrides these pulse defaults.
            state             <= next_state;
            mem_if_resp_ready <= (next_state == ST_IDLE) || (next_state == ST_WAIT);
            wb_ack_o          <= 1'b0;
            wb_err_o          <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        mem_if_req_valid <= 1'b1;
                        aborted          <= 1'b0;
                        mem_if_req       <= {new_tid,
                                             wb_we_i ? OP_WRITE : OP_READ,
                                             32'(wb_addr_i),
                                             wb_we_i ? 32'(wb_data_i) : 32'h0,
                                             4'(wb_sel_i)};
                    end
                end

                ST_REQ: begin
                    if (!wb_cyc_i) aborted <= 1'b1;
                    if (req_fire) begin
                        mem_if_req_valid <= 1'b0;
                        tid_cnt          <= tid_cnt + 8'd1;
                        timeout_cnt      <= 16'h0000;
                    end
                end

                ST_WAIT: begin
                    if (!wb_cyc_i) aborted <= 1'b1;
                    if (resp_match) begin
                        if (!abort_now) begin
                            if (resp_ok) begin
                                wb_ack_o <= 1'b1;
                                if (!req_is_write) wb_data_o <= BUS_WIDTH'(resp_data);
                            end else begin
                                wb_err_o <= 1'b1;
                            end
                        end
                    end else if (timeout_hit) begin
                        if (!abort_now) wb_err_o <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end

                default: ;
            endcase
        end
    end

endmodule
